// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory farm DDR load path
package mem_pkg;
   localparam int LINE_BYTES      = 32;
   localparam int BEATS_PER_LINE  = 4;
   localparam int DDR_ADDR_WIDTH  = 32;
   localparam int SRAM_ADDR_WIDTH = 19;
   localparam int BEAT_WIDTH      = 64;
   localparam int LINE_WIDTH      = 256;
   localparam int NUM_VALID_WIDTH = $clog2(LINE_BYTES);

   typedef struct packed {
      logic [LINE_WIDTH-1:0]      data;
      logic [SRAM_ADDR_WIDTH-1:0] addr;
      logic                       last;
      logic [NUM_VALID_WIDTH-1:0] num_valid;
   } ddr_line_s;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ldr_state_e;
endpackage

// File: rtl/mem_line_fifo.sv
// rtl/mem_line_fifo.sv - synchronous FIFO of SRAM lines with occupancy count
module mem_line_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  ddr_line_s              push_data_i,
   input  logic                   pop_i,
   output ddr_line_s              head_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PW = $clog2(DEPTH);

   ddr_line_s     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_pop;
   logic          do_push;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != (PW+1)'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/mem_ddr_loader.sv
// rtl/mem_ddr_loader.sv - DDR-to-SRAM line fetch engine with credit-based read issue
module mem_ddr_loader
   import mem_pkg::*;
#(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [DDR_ADDR_WIDTH-1:0]  cmd_ddr_addr,
   input  logic [SRAM_ADDR_WIDTH-1:0] cmd_sram_addr,
   input  logic [18:0]                cmd_size_bytes,
   output logic                       cmd_err,
   output logic                       ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0]  ddr_rd_addr,
   input  logic                       ddr_rd_gnt,
   input  logic                       ddr_rd_valid,
   input  logic [BEAT_WIDTH-1:0]      ddr_rd_data,
   output logic                       line_valid,
   input  logic                       line_ready,
   output logic [LINE_WIDTH-1:0]      line_data,
   output logic [SRAM_ADDR_WIDTH-1:0] line_addr,
   output logic                       line_last,
   output logic [NUM_VALID_WIDTH-1:0] line_num_valid,
   output logic                       busy
);
   localparam int BCNT_W = 16;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int CRED_W = 8;

   ldr_state_e                 state_q;
   logic                       cmd_err_q;
   logic [DDR_ADDR_WIDTH-1:0]  rd_addr_q;
   logic [BCNT_W-1:0]          grant_left_q;
   logic [BCNT_W-1:0]          rx_left_q;
   logic [OUT_W-1:0]           outstanding_q;
   logic [1:0]                 pack_idx_q;
   logic [LINE_WIDTH-1:0]      pack_data_q;
   logic [SRAM_ADDR_WIDTH-1:0] sram_q;
   logic [NUM_VALID_WIDTH-1:0] num_valid_q;

   logic              cmd_legal;
   logic [BCNT_W-1:0] beats_w;
   logic [CRED_W-1:0] buffered_w;
   logic              gnt_fire;
   logic              beat_fire;
   logic              line_push;
   logic              line_pop;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   ddr_line_s         push_line;
   ddr_line_s         head;

   assign cmd_legal = (cmd_ddr_addr[2:0] == 3'd0) && (cmd_size_bytes != '0);
   assign beats_w   = BCNT_W'((cmd_size_bytes + 19'd7) >> 3);

   // Beats already committed to this engine: queued lines count as full, plus packer and in-flight.
   assign buffered_w = CRED_W'({fifo_count, 2'b00}) + CRED_W'(pack_idx_q) + CRED_W'(outstanding_q);

   assign ddr_rd_req = (state_q == ST_RUN) && (grant_left_q != '0)
                    && (buffered_w < CRED_W'(FIFO_DEPTH * BEATS_PER_LINE))
                    && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign gnt_fire   = ddr_rd_req && ddr_rd_gnt;
   assign beat_fire  = ddr_rd_valid && (state_q != ST_IDLE);
   assign line_push  = beat_fire && ((pack_idx_q == 2'd3) || (rx_left_q == BCNT_W'(1)));
   assign line_pop   = !fifo_empty && line_ready;

   always_comb begin
      push_line.data = pack_data_q;
      push_line.data[{pack_idx_q, 6'd0} +: BEAT_WIDTH] = ddr_rd_data;
      push_line.addr      = sram_q;
      push_line.last      = (rx_left_q == BCNT_W'(1));
      push_line.num_valid = num_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cmd_err_q     <= 1'b0;
         rd_addr_q     <= '0;
         grant_left_q  <= '0;
         rx_left_q     <= '0;
         outstanding_q <= '0;
         pack_idx_q    <= '0;
         pack_data_q   <= '0;
         sram_q        <= '0;
         num_valid_q   <= '0;
      end else begin
         cmd_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_legal) begin
                     state_q      <= ST_RUN;
                     rd_addr_q    <= cmd_ddr_addr;
                     grant_left_q <= beats_w;
                     rx_left_q    <= beats_w;
                     sram_q       <= cmd_sram_addr;
                     num_valid_q  <= cmd_size_bytes[NUM_VALID_WIDTH-1:0];
                     pack_idx_q   <= '0;
                     pack_data_q  <= '0;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            ST_RUN:   if (gnt_fire && (grant_left_q == BCNT_W'(1))) state_q <= ST_DRAIN;
            ST_DRAIN: if (line_pop && head.last) state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase

         if (gnt_fire) begin
            rd_addr_q    <= rd_addr_q + DDR_ADDR_WIDTH'(8);
            grant_left_q <= grant_left_q - BCNT_W'(1);
         end

         case ({gnt_fire, beat_fire})
            2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
            2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
            default: outstanding_q <= outstanding_q;
         endcase

         if (beat_fire) begin
            rx_left_q <= rx_left_q - BCNT_W'(1);
            if (line_push) begin
               pack_idx_q  <= '0;
               pack_data_q <= '0;
               sram_q      <= sram_q + SRAM_ADDR_WIDTH'(1);
            end else begin
               pack_idx_q  <= pack_idx_q + 2'd1;
               pack_data_q <= push_line.data;
            end
         end
      end
   end

   mem_line_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_line_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (line_push),
      .push_data_i (push_line),
      .pop_i       (line_pop),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign cmd_ready      = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign cmd_err        = cmd_err_q;
   assign ddr_rd_addr    = rd_addr_q;
   assign line_valid     = !fifo_empty;
   assign line_data      = head.data;
   assign line_addr      = head.addr;
   assign line_last      = head.last;
   assign line_num_valid = head.num_valid;
endmodule

// File: tb/tb_mem_ddr_loader.sv
// tb/tb_mem_ddr_loader.sv - scoreboard bench for mem_ddr_loader with a DDR read model
module tb_mem_ddr_loader;
   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [31:0]  cmd_ddr_addr;
   logic [18:0]  cmd_sram_addr;
   logic [18:0]  cmd_size_bytes;
   logic         cmd_err;
   logic         ddr_rd_req;
   logic [31:0]  ddr_rd_addr;
   logic         ddr_rd_gnt;
   logic         ddr_rd_valid;
   logic [63:0]  ddr_rd_data;
   logic         line_valid;
   logic         line_ready;
   logic [255:0] line_data;
   logic [18:0]  line_addr;
   logic         line_last;
   logic [4:0]   line_num_valid;
   logic         busy;

   always #5 clk = ~clk;

   mem_ddr_loader dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ddr_addr   (cmd_ddr_addr),
      .cmd_sram_addr  (cmd_sram_addr),
      .cmd_size_bytes (cmd_size_bytes),
      .cmd_err        (cmd_err),
      .ddr_rd_req     (ddr_rd_req),
      .ddr_rd_addr    (ddr_rd_addr),
      .ddr_rd_gnt     (ddr_rd_gnt),
      .ddr_rd_valid   (ddr_rd_valid),
      .ddr_rd_data    (ddr_rd_data),
      .line_valid     (line_valid),
      .line_ready     (line_ready),
      .line_data      (line_data),
      .line_addr      (line_addr),
      .line_last      (line_last),
      .line_num_valid (line_num_valid),
      .busy           (busy)
   );

   typedef struct {
      logic [255:0] data;
      logic [18:0]  addr;
      logic         last;
      logic [4:0]   nv;
      int           nb;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      int          t;
   } flight_t;

   exp_t        exp_q[$];
   flight_t     fl_q[$];
   logic [31:0] gaddr_q[$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, granted = 0, consumed = 0, max_buf = 0, lines_seen = 0;
   bit hold_ready = 0, rand_ready = 0, rand_gnt = 0;
   int dly_min = 2, dly_max = 2;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] beat_of(input logic [31:0] a);
      return {a ^ 32'hC3A5_5A3C, a};
   endfunction

   task automatic push_exp(input logic [31:0] daddr, input logic [18:0] saddr, input int size);
      int   beats = (size + 7) / 8;
      int   lines = (size + 31) / 32;
      exp_t e;
      for (int l = 0; l < lines; l++) begin
         e.data = '0;
         e.nb   = 0;
         for (int b = 0; b < 4; b++) begin
            if (l * 4 + b < beats) begin
               e.data[b*64 +: 64] = beat_of(daddr + 32'(8 * (l * 4 + b)));
               e.nb++;
            end
         end
         e.addr = saddr + 19'(l);
         e.last = (l == lines - 1);
         e.nv   = 5'(size % 32);
         exp_q.push_back(e);
      end
   endtask

   // DDR read model and line sink; everything changes on the falling edge.
   initial begin
      exp_t e;
      ddr_rd_gnt = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0; line_ready = 1'b0;
      forever begin
         @(negedge clk);
         line_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         if (!rst && line_valid && line_ready) begin
            lines_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_line", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("line_data", line_data, e.data);
               chk("line_addr", line_addr, e.addr);
               chk("line_last", line_last, e.last);
               if (e.last) chk("line_num_valid", line_num_valid, e.nv);
               consumed += e.nb;
            end
         end
         ddr_rd_gnt = !rst && ddr_rd_req && (rand_gnt ? ($urandom_range(0, 2) != 0) : 1'b1);
         if (ddr_rd_gnt) begin
            fl_q.push_back('{ddr_rd_addr, cyc + int'($urandom_range(dly_min, dly_max))});
            gaddr_q.push_back(ddr_rd_addr);
            granted++;
         end
         if (fl_q.size() > 0 && fl_q[0].t <= cyc) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = beat_of(fl_q[0].a);
            void'(fl_q.pop_front());
         end else begin
            ddr_rd_valid = 1'b0;
            ddr_rd_data  = {$urandom, $urandom};
         end
         if (granted - consumed > max_buf) max_buf = granted - consumed;
         cyc++;
      end
   end

   task automatic send(input logic [31:0] daddr, input logic [18:0] saddr, input int size,
                       input bit exp_err);
      @(posedge clk); #1;
      cmd_valid      = 1'b1;
      cmd_ddr_addr   = daddr;
      cmd_sram_addr  = saddr;
      cmd_size_bytes = 19'(size);
      if (!exp_err) push_exp(daddr, saddr, size);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("cmd_err", cmd_err, exp_err);
      chk("busy_after_cmd", busy, !exp_err);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", busy || (exp_q.size() != 0), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_cmd_err"}, cmd_err, 0);
      chk({tag, "_rd_req"}, ddr_rd_req, 0);
      chk({tag, "_rd_addr"}, ddr_rd_addr, 0);
      chk({tag, "_line_valid"}, line_valid, 0);
      chk({tag, "_line_data"}, line_data, 0);
      chk({tag, "_line_addr"}, line_addr, 0);
      chk({tag, "_line_last"}, line_last, 0);
      chk({tag, "_num_valid"}, line_num_valid, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g0;
      int l0;
      logic [31:0] da;
      rst = 1'b1; cmd_valid = 1'b0; cmd_ddr_addr = '0; cmd_sram_addr = '0; cmd_size_bytes = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Two full lines, fixed 2-cycle read latency
      gaddr_q.delete();
      send(32'h1000, 19'h10, 64, 0);
      wait_idle(300);
      chk("t1_beats", gaddr_q.size(), 8);
      for (int i = 0; i < gaddr_q.size() && i < 8; i++)
         chk("t1_rd_addr", gaddr_q[i], 32'h1000 + 32'(8 * i));
      chk("t1_busy_low", busy, 0);

      // Partial final line of one beat
      gaddr_q.delete();
      send(32'h2000, 19'h20, 40, 0);
      wait_idle(300);
      chk("t2_beats", gaddr_q.size(), 5);

      // Backpressure: credits cap the beats taken in
      hold_ready = 1; granted = 0; consumed = 0; max_buf = 0;
      send(32'h4000, 19'h100, 256, 0);
      repeat (50) begin @(posedge clk); #1; end
      chk("t3_granted", granted, 8);
      chk("t3_req_blocked", ddr_rd_req, 0);
      chk("t3_line_valid", line_valid, 1);
      chk("t3_held_data", line_data, exp_q[0].data);
      hold_ready = 0;
      wait_idle(600);
      chk("t3_max_buffered_le8", max_buf <= 8, 1);

      // Illegal commands
      g0 = granted;
      send(32'h1004, 19'h10, 64, 1);
      @(posedge clk); #1;
      chk("t4_err_one_cycle", cmd_err, 0);
      chk("t4_cmd_ready", cmd_ready, 1);
      send(32'h1000, 19'h10, 0, 1);
      @(posedge clk); #1;
      chk("t4b_err_one_cycle", cmd_err, 0);
      chk("t4b_cmd_ready", cmd_ready, 1);
      chk("t4_no_grants", granted - g0, 0);

      // Reset mid-transfer with three beats in flight
      dly_min = 12; dly_max = 12;
      send(32'h8000, 19'h200, 256, 0);
      n = 0;
      while (fl_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
      chk("t5_three_in_flight", fl_q.size(), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("t5_reset");
      rst = 1'b0;
      exp_q.delete();
      granted = 0; consumed = 0;
      l0 = lines_seen;
      n = 0;
      while (fl_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
      repeat (3) begin @(posedge clk); #1; end
      chk("t5_stale_ignored_busy", busy, 0);
      chk("t5_stale_no_line", lines_seen - l0, 0);
      dly_min = 2; dly_max = 2;
      send(32'h9000, 19'h300, 32, 0);
      wait_idle(300);
      chk("t5_one_line", lines_seen - l0, 1);

      // SRAM address wrap, then randomised traffic
      send(32'h0, 19'h7FFFF, 64, 0);
      wait_idle(300);
      rand_gnt = 1; rand_ready = 1; dly_min = 1; dly_max = 5;
      for (int s = 0; s < 100; s++) begin
         da = (s % 10 == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFF8);
         send(da, 19'($urandom), int'($urandom_range(1, 300)), 0);
         wait_idle(4000);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_ddr_loader.md
Name: mem_ddr_loader

Overview:
Fetch engine that sits directly upstream of the memory farm's SRAM demux and performs the read-from-DDR load path. On a software command (DDR byte address, SRAM line address, byte count), it issues 64-bit DDR read beats under credit-based flow control. It packs returned beats into 256-bit lines and streams them to the farm with a per-line SRAM address, a last flag and a count of valid bytes in the last line. A small line FIFO absorbs backpressure from the busy demux.

Parameters:
DDR_ADDR_WIDTH, 32, DDR byte address width
SRAM_ADDR_WIDTH, 19, SRAM line address width
BEAT_WIDTH, 64, DDR read data width (fixed 4 beats per line)
LINE_WIDTH, 256, SRAM line width (32 bytes)
FIFO_DEPTH, 2, line FIFO entries (power of 2)
MAX_OUTSTANDING, 8, maximum DDR beats in flight

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  start request from SW regs
cmd_ready  out  1  high in IDLE only
cmd_ddr_addr  in  32  DDR start byte address, 8-byte aligned
cmd_sram_addr  in  19  first SRAM line address
cmd_size_bytes  in  19  transfer length in bytes, 1..2^18
cmd_err  out  1  1-cycle pulse when command rejected
ddr_rd_req  out  1  beat read request
ddr_rd_addr  out  32  beat byte address
ddr_rd_gnt  in  1  request accepted this cycle
ddr_rd_valid  in  1  returned beat valid (in order, latency >=1)
ddr_rd_data  in  64  returned beat
line_valid  out  1  line available to demux
line_ready  in  1  demux accepts (= !demux_busy)
line_data  out  256  packed line, beat0 in [63:0]
line_addr  out  19  SRAM line address
line_last  out  1  final line of transfer
line_num_valid  out  5  valid bytes in line_last line, 0 encodes 32
busy  out  1  high from accept until last line handed off

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; all counters and FIFO pointers cleared. cmd_ready=1; cmd_err=0; ddr_rd_req=0; ddr_rd_addr=0; line_valid=0; line_data=0; line_addr=0; line_last=0; line_num_valid=0; busy=0. Reset mid-transfer discards all in-flight beats. The DDR side must also be reset; late ddr_rd_valid after reset is ignored in IDLE.
- Command accept: cmd_valid && cmd_ready. Reject with cmd_err pulse the next cycle if ddr_addr[2:0]!=0 or size_bytes==0; the state stays IDLE.
- Derived values: beats = ceil(size/8); lines = ceil(size/32); line_num_valid = size[4:0] (0 means full line). A partial final line is zero-padded in missing beats; bytes beyond size within a beat pass through unmodified.
- States:
  - IDLE -> RUN on a legal accept.
  - RUN -> DRAIN when all beats are granted.
  - DRAIN -> IDLE when the last line handshake occurs (line_valid && line_ready && line_last).
- Credit rule: credits = FIFO_DEPTH*4 - 4*fifo_count - packer_beats - outstanding.
  - ddr_rd_req=1 in RUN iff credits>0, outstanding<MAX_OUTSTANDING and beats remain.
  - On gnt, ddr_rd_addr += 8 and outstanding++. On ddr_rd_valid, outstanding--. Both in the same cycle leave outstanding unchanged.
  - ddr_rd_req/ddr_rd_addr are held stable until gnt.
- Packer: a 2-bit beat index. On the 4th beat, or the final beat of the transfer, the line is pushed into the FIFO with line_addr = sram_base + line_index, and last is set for the final line. Push and pop in the same cycle are allowed; the credit rule guarantees the FIFO never overflows.
- Output: FIFO head drives line_*; line_valid = !fifo_empty. Data is held stable while line_valid && !line_ready.
- Latency: ddr_rd_valid of the 4th beat -> line_valid at the next edge (1 cycle) with an empty FIFO.
- SRAM address wraps modulo 2^19; the DDR address wraps modulo 2^32. Neither wrap is flagged.
- cmd_valid while busy is ignored (no err).

Decomposition:
- mem_pkg (shared): LINE_BYTES=32, BEATS_PER_LINE=4, and typedef ddr_line_s {data[255:0], addr[18:0], last, num_valid[4:0]} used by the FIFO entry and the farm demux input.
- Sub-module mem_line_fifo: a parameterised synchronous FIFO of ddr_line_s with count output. It is reusable for the write-to-DDR path.

Test Plan:
1. ddr_addr=0x1000, sram=0x10, size=64, zero-latency gnt, valid 2 cycles after gnt, line_ready=1 -> 8 beats at 0x1000..0x1038; lines at addr 0x10 and 0x11; second has last=1, num_valid=0; busy low after.
2. size=40 -> 5 beats; line 2 carries beat4 in [63:0] with [255:64]=0; last=1, num_valid=8.
3. line_ready=0 for 50 cycles, size=256 -> at most 8 beats granted and never more than FIFO_DEPTH*4 beats buffered. Releasing ready delivers 8 lines in order with correct data and no loss.
4. ddr_addr=0x1004 or size=0 -> cmd_err pulse one cycle later; no ddr_rd_req; cmd_ready stays 1.
5. rst asserted mid-RUN with 3 beats outstanding, then a new size=32 command -> all outputs at reset values the cycle after. Stale ddr_rd_valid is ignored; the new transfer yields exactly 1 line with correct data.
6. sram=0x7FFFF, size=64 -> line addresses 0x7FFFF then 0x00000; random gnt/valid delays with 100 seeds and a scoreboard check all data.
